fu_arbiter: RTL

FU_ARBITER -- requirements
Module: fu_arbiter

---
 rtl/fu_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fu_arbiter.sv
// rtl/fu_arbiter.sv - two-requester round-robin arbiter sharing an external 3-input function unit
// Also runs an 8-entry truth-table sweep of the unit on request.
module fu_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [2:0] op0,
  output logic       gnt0,
  output logic       rsp0_valid,
  output logic       rsp0_data,
  input  logic       req1,
  input  logic [2:0] op1,
  output logic       gnt1,
  output logic       rsp1_valid,
  output logic       rsp1_data,
  input  logic       sweep_start,
  output logic       sweep_busy,
  output logic       sweep_done,
  output logic [7:0] truth_table,
  output logic       fu_a1,
  output logic       fu_a2,
  output logic       fu_a3,
  input  logic       fu_y
);

  typedef enum logic [1:0] {IDLE, ISSUE, SWEEP} state_t;

  state_t     r_state;
  logic       r_rr;
  logic       r_id;
  logic [2:0] r_idx;
  logic       r_drv;
  logic       r_last;
  logic [2:0] r_fu;
  logic       r_gnt0, r_gnt1;
  logic       r_rsp0_valid, r_rsp1_valid;
  logic       r_rsp0_data, r_rsp1_data;
  logic       r_busy, r_done;
  logic [7:0] r_tt;

  logic       w_any;
  logic       w_pick;
  logic [2:0] w_op;

  assign w_any  = req0 | req1;
  assign w_pick = (req0 & req1) ? r_rr : req1;
  assign w_op   = w_pick ? op1 : op0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rr         <= 1'b0;
      r_id         <= 1'b0;
      r_idx        <= 3'd0;
      r_drv        <= 1'b0;
      r_last       <= 1'b0;
      r_fu         <= 3'd0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= 1'b0;
      r_rsp1_data  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tt         <= 8'd0;
    end else begin
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sweep_start) begin
            r_state <= SWEEP;
            r_busy  <= 1'b1;
            r_idx   <= 3'd0;
            r_drv   <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_any) begin
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_fu    <= w_op;
            r_id    <= w_pick;
            r_rr    <= ~w_pick;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_id) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_data  <= fu_y;
          end else begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_data  <= fu_y;
          end
          r_state <= IDLE;
        end
        SWEEP: begin
          // fu_y seen now is the response to the index driven one cycle earlier
          if (!r_last) begin
            r_fu  <= r_idx;
            r_drv <= 1'b1;
            if (r_drv) r_tt[r_idx - 3'd1] <= fu_y;
            if (r_idx == 3'd7) r_last <= 1'b1;
            else               r_idx  <= r_idx + 3'd1;
          end else begin
            r_tt[7] <= fu_y;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
            r_drv   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_data   = r_rsp0_data;
  assign rsp1_data   = r_rsp1_data;
  assign sweep_busy  = r_busy;
  assign sweep_done  = r_done;
  assign truth_table = r_tt;
  assign fu_a1       = r_fu[2];
  assign fu_a2       = r_fu[1];
  assign fu_a3       = r_fu[0];

endmodule
